// File: rtl/br_resolve_if.sv
// Fetch/execute-facing bundle of the branch resolution unit: push from fetch,
// resolve from execute, flush/redirect and BHT lookup back to fetch.
interface br_resolve_if #(parameter int DEPTH = 4);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push_i;
  logic [31:0]      push_pc_i;
  logic             push_pred_i;
  logic [31:0]      push_target_i;
  logic             full_o;
  logic [CNT_W-1:0] count_o;
  logic             res_valid_i;
  logic             res_taken_i;
  logic [31:0]      res_target_i;
  logic             flush_o;
  logic [31:0]      redirect_pc_o;
  logic             ovf_o;
  logic             unf_o;
  logic [31:0]      lookup_pc_i;
  logic             lookup_taken_o;

  modport slave (
    input  push_i, push_pc_i, push_pred_i, push_target_i,
    input  res_valid_i, res_taken_i, res_target_i, lookup_pc_i,
    output full_o, count_o, flush_o, redirect_pc_o, ovf_o, unf_o, lookup_taken_o
  );

  modport master (
    output push_i, push_pc_i, push_pred_i, push_target_i,
    output res_valid_i, res_taken_i, res_target_i, lookup_pc_i,
    input  full_o, count_o, flush_o, redirect_pc_o, ovf_o, unf_o, lookup_taken_o
  );
endinterface

// File: rtl/br_resolve_unit.sv
// In-order in-flight branch queue: checks execute outcomes against predictions,
// raises flush/redirect on mispredict and trains a 2-bit BHT read by fetch.
module br_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int BHT_IDX_W = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  br_resolve_if.slave   bif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [1:0]       bht_q [BHT_N];
  logic [1:0]       bht_d [BHT_N];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]      redirect_q, redirect_d;

  ent_t                 head;
  logic                 full, empty, pop, mis, push_ok;
  logic [BHT_IDX_W-1:0] upd_idx;

  always_comb begin
    head    = ent_q[rd_ptr_q];
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == '0);
    pop     = bif.res_valid_i & ~empty;
    mis     = pop & ((head.pred != bif.res_taken_i) |
                     (bif.res_taken_i & (head.tgt != bif.res_target_i)));
    // A push into a full queue rides on a same-cycle pop; a mispredict kills it as wrong-path.
    push_ok = bif.push_i & (~full | pop) & ~mis;
    upd_idx = head.pc[BHT_IDX_W+1:2];

    ent_d    = ent_q;
    bht_d    = bht_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

    if (push_ok) begin
      ent_d[wr_ptr_q] = '{pc: bif.push_pc_i, pred: bif.push_pred_i, tgt: bif.push_target_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (bif.res_taken_i) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
    if (mis) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    flush_d    = mis;
    redirect_d = redirect_q;
    if (mis) redirect_d = bif.res_taken_i ? bif.res_target_i : head.pc + 32'd4;
    ovf_d      = bif.push_i & full & ~pop;
    unf_d      = bif.res_valid_i & empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      bht_q      <= bht_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bif.full_o         = full;
  assign bif.count_o        = cnt_q;
  assign bif.flush_o        = flush_q;
  assign bif.redirect_pc_o  = redirect_q;
  assign bif.ovf_o          = ovf_q;
  assign bif.unf_o          = unf_q;
  assign bif.lookup_taken_o = bht_q[bif.lookup_pc_i[BHT_IDX_W+1:2]][1];
endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: queue, mispredict redirect, BHT training,
// overflow/underflow pulses and async reset.
module tb_br_resolve_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  br_resolve_if #(.DEPTH(4)) bif();

  br_resolve_unit #(.DEPTH(4), .BHT_IDX_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bif     (bif)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    bif.push_i = 1'b1; bif.push_pc_i = pc; bif.push_pred_i = pred; bif.push_target_i = tgt;
    cyc();
    bif.push_i = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    bif.res_valid_i = 1'b1; bif.res_taken_i = taken; bif.res_target_i = tgt;
    cyc();
    bif.res_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bif.push_i = 0; bif.push_pc_i = 0; bif.push_pred_i = 0; bif.push_target_i = 0;
    bif.res_valid_i = 0; bif.res_taken_i = 0; bif.res_target_i = 0;
    bif.lookup_pc_i = 32'h40;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cyc();
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL reset_lookup got=%0b exp=0", bif.lookup_taken_o); end
    checks++; if (bif.count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bif.count_o); end
    checks++; if (bif.full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bif.full_o); end
    checks++; if ({bif.flush_o, bif.ovf_o, bif.unf_o} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {bif.flush_o, bif.ovf_o, bif.unf_o}); end
    checks++; if (bif.redirect_pc_o !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%h exp=0", bif.redirect_pc_o); end
  endtask

  task automatic test_correct_taken();
    push_one(32'h100, 1'b1, 32'h200);
    checks++; if (bif.count_o !== 3'd1) begin failures++; $display("FAIL ct_count1 got=%0d exp=1", bif.count_o); end
    bif.lookup_pc_i = 32'h100;
    bif.res_valid_i = 1'b1; bif.res_taken_i = 1'b1; bif.res_target_i = 32'h200;
    #1;
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL ct_preupdate got=%0b exp=0", bif.lookup_taken_o); end
    cyc();
    bif.res_valid_i = 1'b0;
    checks++; if (bif.flush_o !== 1'b0) begin failures++; $display("FAIL ct_flush got=%0b exp=0", bif.flush_o); end
    checks++; if (bif.count_o !== 3'd0) begin failures++; $display("FAIL ct_count0 got=%0d exp=0", bif.count_o); end
    checks++; if (bif.lookup_taken_o !== 1'b1) begin failures++; $display("FAIL ct_bht got=%0b exp=1", bif.lookup_taken_o); end
  endtask

  task automatic test_mispredict_nt();
    push_one(32'h100, 1'b1, 32'h200);
    push_one(32'h104, 1'b0, 32'h0);
    push_one(32'h108, 1'b0, 32'h0);
    checks++; if (bif.count_o !== 3'd3) begin failures++; $display("FAIL mn_count3 got=%0d exp=3", bif.count_o); end
    resolve(1'b0, 32'h0);
    checks++; if (bif.flush_o !== 1'b1) begin failures++; $display("FAIL mn_flush got=%0b exp=1", bif.flush_o); end
    checks++; if (bif.redirect_pc_o !== 32'h104) begin failures++; $display("FAIL mn_redirect got=%h exp=104", bif.redirect_pc_o); end
    checks++; if (bif.count_o !== 3'd0) begin failures++; $display("FAIL mn_count0 got=%0d exp=0", bif.count_o); end
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL mn_bht got=%0b exp=0", bif.lookup_taken_o); end
    cyc();
    checks++; if (bif.flush_o !== 1'b0) begin failures++; $display("FAIL mn_flush_drop got=%0b exp=0", bif.flush_o); end
  endtask

  task automatic test_wrap();
    bif.lookup_pc_i = 32'hFFFF_FFFC;
    push_one(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(1'b1, 32'h10);
    checks++; if (bif.flush_o !== 1'b1) begin failures++; $display("FAIL wr_flush1 got=%0b exp=1", bif.flush_o); end
    checks++; if (bif.redirect_pc_o !== 32'h10) begin failures++; $display("FAIL wr_redirect1 got=%h exp=10", bif.redirect_pc_o); end
    checks++; if (bif.lookup_taken_o !== 1'b1) begin failures++; $display("FAIL wr_bht1 got=%0b exp=1", bif.lookup_taken_o); end
    push_one(32'hFFFF_FFFC, 1'b1, 32'h500);
    checks++; if (bif.flush_o !== 1'b0) begin failures++; $display("FAIL wr_flush_gap got=%0b exp=0", bif.flush_o); end
    resolve(1'b0, 32'h0);
    checks++; if (bif.flush_o !== 1'b1) begin failures++; $display("FAIL wr_flush2 got=%0b exp=1", bif.flush_o); end
    checks++; if (bif.redirect_pc_o !== 32'h0) begin failures++; $display("FAIL wr_redirect2 got=%h exp=0", bif.redirect_pc_o); end
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL wr_bht2 got=%0b exp=0", bif.lookup_taken_o); end
    cyc();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i), 1'b0, 32'h0);
    checks++; if (bif.count_o !== 3'd4) begin failures++; $display("FAIL fu_count4 got=%0d exp=4", bif.count_o); end
    checks++; if (bif.full_o !== 1'b1) begin failures++; $display("FAIL fu_full got=%0b exp=1", bif.full_o); end
    checks++; if (bif.ovf_o !== 1'b0) begin failures++; $display("FAIL fu_ovf_pre got=%0b exp=0", bif.ovf_o); end
    push_one(32'h210, 1'b0, 32'h0);
    checks++; if (bif.ovf_o !== 1'b1) begin failures++; $display("FAIL fu_ovf got=%0b exp=1", bif.ovf_o); end
    checks++; if (bif.count_o !== 3'd4) begin failures++; $display("FAIL fu_count_ovf got=%0d exp=4", bif.count_o); end
    cyc();
    checks++; if (bif.ovf_o !== 1'b0) begin failures++; $display("FAIL fu_ovf_drop got=%0b exp=0", bif.ovf_o); end
    // push + correct pop while full
    bif.push_i = 1'b1; bif.push_pc_i = 32'h214; bif.push_pred_i = 1'b0; bif.push_target_i = 32'h0;
    bif.res_valid_i = 1'b1; bif.res_taken_i = 1'b0; bif.res_target_i = 32'h0;
    cyc();
    bif.push_i = 1'b0; bif.res_valid_i = 1'b0;
    checks++; if (bif.count_o !== 3'd4) begin failures++; $display("FAIL fu_pp_count got=%0d exp=4", bif.count_o); end
    checks++; if ({bif.ovf_o, bif.flush_o} !== 2'b00) begin failures++; $display("FAIL fu_pp_pulses got=%b exp=00", {bif.ovf_o, bif.flush_o}); end
    // push + mispredicting pop while full: push discarded silently
    bif.push_i = 1'b1; bif.push_pc_i = 32'h218; bif.push_pred_i = 1'b0; bif.push_target_i = 32'h0;
    bif.res_valid_i = 1'b1; bif.res_taken_i = 1'b1; bif.res_target_i = 32'h999;
    cyc();
    bif.push_i = 1'b0; bif.res_valid_i = 1'b0;
    checks++; if (bif.flush_o !== 1'b1) begin failures++; $display("FAIL fu_mis_flush got=%0b exp=1", bif.flush_o); end
    checks++; if (bif.redirect_pc_o !== 32'h999) begin failures++; $display("FAIL fu_mis_redirect got=%h exp=999", bif.redirect_pc_o); end
    checks++; if (bif.count_o !== 3'd0) begin failures++; $display("FAIL fu_mis_count got=%0d exp=0", bif.count_o); end
    checks++; if (bif.ovf_o !== 1'b0) begin failures++; $display("FAIL fu_mis_ovf got=%0b exp=0", bif.ovf_o); end
    cyc();
  endtask

  task automatic test_bht_sat();
    logic [2:0] exp_seq;
    exp_seq = 3'b111;
    bif.lookup_pc_i = 32'h80;
    for (int i = 0; i < 3; i++) begin
      push_one(32'h80, 1'b1, 32'h84);
      resolve(1'b1, 32'h84);
      checks++; if (bif.lookup_taken_o !== exp_seq[i]) begin failures++; $display("FAIL sat_up%0d got=%0b exp=%0b", i, bif.lookup_taken_o, exp_seq[i]); end
    end
    push_one(32'h80, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    checks++; if (bif.lookup_taken_o !== 1'b1) begin failures++; $display("FAIL sat_dn1 got=%0b exp=1", bif.lookup_taken_o); end
    push_one(32'h80, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL sat_dn2 got=%0b exp=0", bif.lookup_taken_o); end
    checks++; if (bif.flush_o !== 1'b0) begin failures++; $display("FAIL sat_flush got=%0b exp=0", bif.flush_o); end
  endtask

  task automatic test_underflow();
    bif.lookup_pc_i = 32'h214;
    resolve(1'b1, 32'h0);
    checks++; if (bif.unf_o !== 1'b1) begin failures++; $display("FAIL un_unf got=%0b exp=1", bif.unf_o); end
    checks++; if (bif.lookup_taken_o !== 1'b0) begin failures++; $display("FAIL un_bht got=%0b exp=0", bif.lookup_taken_o); end
    checks++; if ({bif.flush_o, bif.count_o} !== 4'b0000) begin failures++; $display("FAIL un_state got=%b exp=0000", {bif.flush_o, bif.count_o}); end
    cyc();
    checks++; if (bif.unf_o !== 1'b0) begin failures++; $display("FAIL un_unf_drop got=%0b exp=0", bif.unf_o); end
  endtask

  task automatic test_async_reset();
    push_one(32'h300, 1'b0, 32'h0);
    push_one(32'h304, 1'b0, 32'h0);
    push_one(32'h308, 1'b1, 32'h400);
    checks++; if (bif.count_o !== 3'd3) begin failures++; $display("FAIL ar_count3 got=%0d exp=3", bif.count_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bif.count_o !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", bif.count_o); end
    checks++; if (bif.flush_o !== 1'b0) begin failures++; $display("FAIL ar_flush got=%0b exp=0", bif.flush_o); end
    @(negedge clk) reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_mispredict_nt();
    test_wrap();
    test_full();
    test_bht_sat();
    test_underflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
